// File: rtl/pong_ball_engine.sv
// Ball physics plus the READY/MOVE/HOLD serve-and-point sequencer for the pong game.
// Coordinates are field-relative centre positions with y growing upward.
module pong_ball_engine #(
  parameter int POS_BITS    = 10,
  parameter int FIELD_W     = 620,
  parameter int FIELD_H     = 360,
  parameter int BALL_R      = 8,
  parameter int BAR_W       = 10,
  parameter int BAR_H       = 60,
  parameter int BAR1_X      = 20,
  parameter int BAR2_X      = 600,
  parameter int VX_MAX      = 6,
  parameter int HITS_PER_UP = 4,
  parameter int HOLD_TICKS  = 60
) (
  input  logic                mclk,
  input  logic                reset_n,
  input  logic                tick,
  input  logic                serve,
  input  logic                pause,
  input  logic [POS_BITS-1:0] bar_1_y,
  input  logic [POS_BITS-1:0] bar_2_y,
  output logic [POS_BITS-1:0] x_ball,
  output logic [POS_BITS-1:0] y_ball,
  output logic                point1,
  output logic                point2,
  output logic [1:0]          state
);

  localparam int S   = POS_BITS + 2;
  localparam int VXW = $clog2(VX_MAX + 1);
  localparam int HW  = $clog2(HITS_PER_UP + 1);
  localparam int CW  = $clog2(HOLD_TICKS + 1);

  typedef logic signed [S-1:0] coord_t;

  localparam coord_t C_R     = coord_t'(BALL_R);
  localparam coord_t C_TOP   = coord_t'(FIELD_H - BALL_R);
  localparam coord_t C_XMAX  = coord_t'(FIELD_W - BALL_R);
  localparam coord_t C_L1    = coord_t'(BAR1_X + BAR_W / 2);
  localparam coord_t C_R2    = coord_t'(BAR2_X - BAR_W / 2);
  localparam coord_t C_REACH = coord_t'(BAR_H / 2 + BALL_R);
  localparam coord_t C_Z0    = coord_t'(BAR_H / 6);
  localparam coord_t C_Z1    = coord_t'(BAR_H / 3);

  localparam logic [POS_BITS-1:0] X_CEN  = POS_BITS'(FIELD_W / 2);
  localparam logic [POS_BITS-1:0] Y_CEN  = POS_BITS'(FIELD_H / 2);
  localparam logic [POS_BITS-1:0] Y_TOP  = POS_BITS'(FIELD_H - BALL_R);
  localparam logic [POS_BITS-1:0] Y_BOT  = POS_BITS'(BALL_R);
  localparam logic [POS_BITS-1:0] X_HIT1 = POS_BITS'(BAR1_X + BAR_W / 2 + BALL_R);
  localparam logic [POS_BITS-1:0] X_HIT2 = POS_BITS'(BAR2_X - BAR_W / 2 - BALL_R);
  localparam logic [VXW-1:0]      VX_INI = VXW'(2);
  localparam logic [VXW-1:0]      VX_TOP = VXW'(VX_MAX);

  typedef enum logic [1:0] {
    ST_READY = 2'b00,
    ST_MOVE  = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [POS_BITS-1:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic [VXW-1:0]      r_vx, w_vx_nxt;
  logic [1:0]          r_vy, w_vy_nxt;
  logic                r_dir_x, r_dir_y, w_dir_x_nxt, w_dir_y_nxt;
  logic [HW-1:0]       r_hits, w_hits_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic                r_point1, r_point2, w_point1_nxt, w_point2_nxt;

  logic   w_step;
  coord_t w_xs, w_ys, w_nx, w_ny, w_dy1, w_dy2, w_off1, w_off2, w_dy, w_off;
  logic   w_hit1, w_hit2, w_hit, w_miss_l, w_miss_r, w_miss;

  assign w_step = tick & ~pause;

  // dir_x/dir_y: 1 = right/up
  assign w_xs = coord_t'(r_x);
  assign w_ys = coord_t'(r_y);
  assign w_nx = r_dir_x ? w_xs + coord_t'(r_vx) : w_xs - coord_t'(r_vx);
  assign w_ny = r_dir_y ? w_ys + coord_t'(r_vy) : w_ys - coord_t'(r_vy);

  assign w_dy1  = w_ys - coord_t'(bar_1_y);
  assign w_dy2  = w_ys - coord_t'(bar_2_y);
  assign w_off1 = w_dy1[S-1] ? -w_dy1 : w_dy1;
  assign w_off2 = w_dy2[S-1] ? -w_dy2 : w_dy2;

  assign w_hit1 = !r_dir_x && (w_xs - C_R > C_L1) && (w_nx - C_R <= C_L1) && (w_off1 <= C_REACH);
  assign w_hit2 = r_dir_x && (w_xs + C_R < C_R2) && (w_nx + C_R >= C_R2) && (w_off2 <= C_REACH);
  assign w_hit  = w_hit1 | w_hit2;
  assign w_dy   = r_dir_x ? w_dy2 : w_dy1;
  assign w_off  = r_dir_x ? w_off2 : w_off1;

  assign w_miss_l = !w_hit && (w_nx <= C_R);
  assign w_miss_r = !w_hit && !w_miss_l && (w_nx >= C_XMAX);
  assign w_miss   = w_miss_l | w_miss_r;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_READY;
      r_x      <= X_CEN;
      r_y      <= Y_CEN;
      r_vx     <= VX_INI;
      r_vy     <= 2'd1;
      r_dir_x  <= 1'b1;
      r_dir_y  <= 1'b1;
      r_hits   <= '0;
      r_cnt    <= '0;
      r_point1 <= 1'b0;
      r_point2 <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_vx     <= w_vx_nxt;
      r_vy     <= w_vy_nxt;
      r_dir_x  <= w_dir_x_nxt;
      r_dir_y  <= w_dir_y_nxt;
      r_hits   <= w_hits_nxt;
      r_cnt    <= w_cnt_nxt;
      r_point1 <= w_point1_nxt;
      r_point2 <= w_point2_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_vx_nxt     = r_vx;
    w_vy_nxt     = r_vy;
    w_dir_x_nxt  = r_dir_x;
    w_dir_y_nxt  = r_dir_y;
    w_hits_nxt   = r_hits;
    w_cnt_nxt    = r_cnt;
    w_point1_nxt = 1'b0;
    w_point2_nxt = 1'b0;
    case (r_state)
      ST_READY: begin
        if (w_step && serve) w_state_nxt = ST_MOVE;
      end
      ST_MOVE: begin
        if (w_step) begin
          if (w_hit) begin
            w_x_nxt     = w_hit1 ? X_HIT1 : X_HIT2;
            w_dir_x_nxt = ~r_dir_x;
            if (w_off < C_Z0) begin
              w_vy_nxt = 2'd0;
            end else begin
              w_vy_nxt    = (w_off < C_Z1) ? 2'd1 : 2'd2;
              w_dir_y_nxt = ~w_dy[S-1];
            end
            if (r_hits == HW'(HITS_PER_UP - 1)) begin
              w_hits_nxt = '0;
              w_vx_nxt   = (r_vx >= VX_TOP) ? VX_TOP : r_vx + 1'b1;
            end else begin
              w_hits_nxt = r_hits + 1'b1;
            end
          end else if (w_miss_l) begin
            w_point2_nxt = 1'b1;
            w_dir_x_nxt  = 1'b0;
            w_state_nxt  = ST_HOLD;
          end else if (w_miss_r) begin
            w_point1_nxt = 1'b1;
            w_dir_x_nxt  = 1'b1;
            w_state_nxt  = ST_HOLD;
          end else begin
            w_x_nxt = w_nx[POS_BITS-1:0];
          end
          // Wall is applied after the paddle so it has the final word on dir_y.
          if (!w_miss) begin
            if (w_ny >= C_TOP) begin
              w_y_nxt     = Y_TOP;
              w_dir_y_nxt = 1'b0;
            end else if (w_ny <= C_R) begin
              w_y_nxt     = Y_BOT;
              w_dir_y_nxt = 1'b1;
            end else begin
              w_y_nxt = w_ny[POS_BITS-1:0];
            end
          end
        end
      end
      ST_HOLD: begin
        if (w_step) begin
          if (r_cnt == CW'(HOLD_TICKS - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_READY;
            w_x_nxt     = X_CEN;
            w_y_nxt     = Y_CEN;
            w_vx_nxt    = VX_INI;
            w_vy_nxt    = 2'd1;
            w_dir_y_nxt = 1'b1;
            w_hits_nxt  = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_READY;
    endcase
  end

  assign x_ball = r_x;
  assign y_ball = r_y;
  assign point1 = r_point1;
  assign point2 = r_point2;
  assign state  = r_state;

endmodule
